// File: rtl/matvec_sequencer.sv
// rtl/matvec_sequencer.sv - fetch/unpack/compute control FSM for the 8x8 matrix-vector MAC array
module matvec_sequencer #(
    parameter int                ROWS      = 8,
    parameter int                COLS      = 8,
    parameter int                DATA_W    = 8,
    parameter int                MEM_W     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAC_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [MEM_W-1:0]  mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [ROWS-1:0]   a_fifo_wr,
    output logic              b_fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic [ROWS-1:0]   a_fifo_full,
    input  logic              b_fifo_full,
    output logic              fifo_rd,
    output logic              mac_clr,
    output logic              mac_en
);

    localparam int WORD_W = $clog2(ROWS + 1);
    localparam int CNT_W  = $clog2(COLS + 1);
    localparam int LAT_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_UNPACK, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [WORD_W-1:0]   r_word, w_word_nxt;
    logic [CNT_W-1:0]    r_byte, w_byte_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [LAT_W-1:0]    r_drain, w_drain_nxt;
    logic [MEM_W-1:0]    r_hold, w_hold_nxt;

    logic                r_busy, r_done, r_mem_read;
    logic [ROWS-1:0]     r_a_wr, w_a_wr;
    logic                r_b_wr, w_b_wr;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic                r_fifo_rd, r_mac_clr, r_mac_en;

    logic                w_is_b;
    logic [ROWS-1:0]     w_row_onehot;
    logic                w_target_full;
    logic [DATA_W-1:0]   w_byte_val;

    // Word index ROWS selects the B vector; the shift then leaves the row mask empty.
    assign w_is_b        = (r_word >= WORD_W'(ROWS));
    assign w_row_onehot  = ROWS'(1) << r_word;
    assign w_target_full = w_is_b ? b_fifo_full : |(a_fifo_full & w_row_onehot);
    assign w_byte_val    = DATA_W'(r_hold >> (r_byte * DATA_W));

    always_comb begin
        w_next      = r_state;
        w_word_nxt  = r_word;
        w_byte_nxt  = r_byte;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain;
        w_hold_nxt  = r_hold;
        w_a_wr      = '0;
        w_b_wr      = 1'b0;
        w_wdata     = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_word_nxt = '0;
                w_next     = S_REQ;
            end
            S_REQ: begin
                if (!mem_waitrequest) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_readdatavalid) begin
                    w_hold_nxt = mem_readdata;
                    w_byte_nxt = '0;
                    w_next     = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (!w_target_full) begin
                    w_a_wr  = w_is_b ? '0 : w_row_onehot;
                    w_b_wr  = w_is_b;
                    w_wdata = w_byte_val;
                    if (r_byte == CNT_W'(COLS - 1)) begin
                        w_byte_nxt = '0;
                        if (!w_is_b) begin
                            w_word_nxt = r_word + WORD_W'(1);
                            w_next     = S_REQ;
                        end else begin
                            w_cnt_nxt = '0;
                            w_next    = S_COMPUTE;
                        end
                    end else begin
                        w_byte_nxt = r_byte + CNT_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (r_cnt == CNT_W'(COLS - 1)) begin
                    w_drain_nxt = '0;
                    w_next      = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                // The first DRAIN cycle still carries the final mac_en.
                if (r_drain == LAT_W'(MAC_LAT - 1)) w_next = S_DONE;
                else w_drain_nxt = r_drain + LAT_W'(1);
            end
            S_DONE: begin
                if (start) w_next = S_CLEAR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_byte     <= '0;
            r_cnt      <= '0;
            r_drain    <= '0;
            r_hold     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_read <= 1'b0;
            r_a_wr     <= '0;
            r_b_wr     <= 1'b0;
            r_wdata    <= '0;
            r_fifo_rd  <= 1'b0;
            r_mac_clr  <= 1'b0;
            r_mac_en   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_word     <= w_word_nxt;
            r_byte     <= w_byte_nxt;
            r_cnt      <= w_cnt_nxt;
            r_drain    <= w_drain_nxt;
            r_hold     <= w_hold_nxt;
            r_busy     <= !(w_next == S_IDLE || w_next == S_DONE);
            r_done     <= (w_next == S_DONE);
            r_mem_read <= (w_next == S_REQ);
            r_a_wr     <= w_a_wr;
            r_b_wr     <= w_b_wr;
            r_wdata    <= w_wdata;
            r_fifo_rd  <= (w_next == S_COMPUTE);
            r_mac_clr  <= (w_next == S_CLEAR);
            // FIFO read data arrives one cycle after fifo_rd.
            r_mac_en   <= r_fifo_rd;
        end
    end

    assign mem_address = BASE_ADDR + ADDR_W'(r_word);
    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_read    = r_mem_read;
    assign a_fifo_wr   = r_a_wr;
    assign b_fifo_wr   = r_b_wr;
    assign fifo_wdata  = r_wdata;
    assign fifo_rd     = r_fifo_rd;
    assign mac_clr     = r_mac_clr;
    assign mac_en      = r_mac_en;

endmodule

// File: tb/tb_matvec_sequencer.sv
// tb/tb_matvec_sequencer.sv - directed/randomized bench with memory, FIFO and MAC reference models
module tb_matvec_sequencer;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DATA_W = 8;
    localparam int MEM_W  = 64;
    localparam int ADDR_W = 32;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_waitrequest   = 1'b0;
    logic              mem_readdatavalid = 1'b0;
    logic [MEM_W-1:0]  mem_readdata      = '0;
    logic [ROWS-1:0]   a_fifo_wr;
    logic              b_fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic [ROWS-1:0]   a_fifo_full = '0;
    logic              b_fifo_full = 1'b0;
    logic              fifo_rd, mac_clr, mac_en;

    matvec_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .MEM_W(MEM_W),
        .ADDR_W(ADDR_W), .BASE_ADDR('0), .MAC_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .a_fifo_wr(a_fifo_wr),
        .b_fifo_wr(b_fifo_wr), .fifo_wdata(fifo_wdata), .a_fifo_full(a_fifo_full),
        .b_fifo_full(b_fifo_full), .fifo_rd(fifo_rd), .mac_clr(mac_clr), .mac_en(mac_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [MEM_W-1:0] mem [0:ROWS];
    int               cfg_delay [0:ROWS];
    int               cfg_stall_addr   = 4;
    int               cfg_stall_cycles = 0;
    logic             stray_en = 1'b0;

    // Memory slave: one request at a time, programmable stall and read latency.
    int   v_resp = 0;
    logic pend = 1'b0;
    int   pend_cnt = 0, pend_word = 0, req_wait = 0;
    logic stall_q = 1'b0;
    logic [ADDR_W-1:0] stall_addr_q = '0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pend = 1'b0; req_wait = 0; stall_q = 1'b0;
            mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
        end else begin
            if (stall_q && !(mem_read && mem_address == stall_addr_q)) v_resp++;
            mem_readdatavalid = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend = 1'b0;
                    mem_readdatavalid = 1'b1;
                    mem_readdata = mem[pend_word];
                end
            end else if (stray_en) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = {$urandom, $urandom};
            end
            mem_waitrequest = 1'b0;
            stall_q = 1'b0;
            if (mem_read) begin
                if (pend) v_resp++;
                else if (int'(mem_address) == cfg_stall_addr && req_wait < cfg_stall_cycles) begin
                    mem_waitrequest = 1'b1;
                    req_wait++;
                    stall_q = 1'b1;
                    stall_addr_q = mem_address;
                end else begin
                    pend = 1'b1;
                    pend_word = int'(mem_address);
                    pend_cnt = cfg_delay[pend_word];
                    req_wait = 0;
                end
            end
        end
    end

    // FIFO + MAC datapath model and strobe accounting.
    logic [ROWS-1:0]   full_q = '0;
    always @(posedge clk) full_q <= a_fifo_full;

    logic [7:0]  aq [0:ROWS-1][$];
    logic [7:0]  bq [$];
    logic [7:0]  dreg_a [0:ROWS-1];
    logic [7:0]  dreg_b = '0;
    logic [31:0] acc [0:ROWS-1];
    int          wr_idx [0:ROWS];
    int c_wr = 0, c_rd = 0, c_en = 0, c_clr = 0, v_mon = 0;

    always @(negedge clk) begin
        logic [MEM_W-1:0] w;
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin aq[r].delete(); acc[r] = '0; dreg_a[r] = '0; end
            bq.delete();
            for (int r = 0; r <= ROWS; r++) wr_idx[r] = 0;
        end else begin
            if (mac_clr) begin
                c_clr++;
                for (int r = 0; r < ROWS; r++) begin aq[r].delete(); acc[r] = '0; end
                bq.delete();
                for (int r = 0; r <= ROWS; r++) wr_idx[r] = 0;
            end
            if (mac_en) begin
                c_en++;
                for (int r = 0; r < ROWS; r++) acc[r] = acc[r] + 32'(dreg_a[r]) * 32'(dreg_b);
            end
            if (!$onehot0({b_fifo_wr, a_fifo_wr})) v_mon++;
            if ((a_fifo_wr & full_q) != '0) v_mon++;
            for (int r = 0; r <= ROWS; r++) begin
                if ((r < ROWS) ? a_fifo_wr[r % ROWS] : b_fifo_wr) begin
                    c_wr++;
                    w = mem[r];
                    if (wr_idx[r] >= COLS || fifo_wdata !== w[8*wr_idx[r] +: 8]) v_mon++;
                    wr_idx[r]++;
                    if (r < ROWS) aq[r].push_back(fifo_wdata);
                    else bq.push_back(fifo_wdata);
                end
            end
            if (fifo_rd) begin
                c_rd++;
                for (int r = 0; r < ROWS; r++) begin
                    if (aq[r].size() == 0) v_mon++;
                    else dreg_a[r] = aq[r].pop_front();
                end
                if (bq.size() == 0) v_mon++;
                else dreg_b = bq.pop_front();
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dot(input int r);
        logic [31:0] s;
        logic [MEM_W-1:0] a, b;
        s = '0; a = mem[r]; b = mem[ROWS];
        for (int j = 0; j < COLS; j++) s = s + 32'(a[8*j +: 8]) * 32'(b[8*j +: 8]);
        return s;
    endfunction

    function automatic int exp_latency(input int extra);
        int l;
        l = 1 + (ROWS + 1) * (COLS + 2) + COLS + 1 + extra;
        if (cfg_stall_addr <= ROWS) l += cfg_stall_cycles;
        for (int w = 0; w <= ROWS; w++) l += cfg_delay[w] - 1;
        return l;
    endfunction

    task automatic fill_nominal();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) mem[i][8*j +: 8] = 8'(16 * i + j + 1);
        for (int j = 0; j < COLS; j++) mem[ROWS][8*j +: 8] = 8'(8'h81 + j);
    endtask

    task automatic cfg_zero();
        cfg_stall_cycles = 0;
        for (int w = 0; w <= ROWS; w++) cfg_delay[w] = 1;
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({busy, done, mem_read, a_fifo_wr, b_fifo_wr, fifo_wdata, fifo_rd, mac_clr, mac_en});
    endfunction

    // hook 1: stray readdatavalid during UNPACK of word 0; hook 2: a_fifo_full[2] for 4 cycles in row 2
    task automatic run_case(input string tag, input int exp_lat, input int hook);
        int lat, wr0, rd0, en0, clr0, v0, left;
        wr0 = c_wr; rd0 = c_rd; en0 = c_en; clr0 = c_clr; v0 = v_mon + v_resp;
        lat = -1;
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            stray_en = (hook == 1 && k == 5);
            a_fifo_full[2] = (hook == 2 && k >= 25 && k <= 28);
            if (done) begin lat = k; break; end
        end
        stray_en = 1'b0; a_fifo_full = '0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        for (int r = 0; r < ROWS; r++) check($sformatf("%s result[%0d]", tag, r), 64'(acc[r]), 64'(dot(r)));
        check({tag, " fifo_writes"}, 64'(c_wr - wr0), 64'((ROWS + 1) * COLS));
        check({tag, " fifo_rd_cycles"}, 64'(c_rd - rd0), 64'(COLS));
        check({tag, " mac_en_cycles"}, 64'(c_en - en0), 64'(COLS));
        check({tag, " mac_clr_pulses"}, 64'(c_clr - clr0), 64'd1);
        check({tag, " protocol_violations"}, 64'(v_mon + v_resp - v0), 64'd0);
        left = bq.size();
        for (int r = 0; r < ROWS; r++) left += aq[r].size();
        check({tag, " fifo_leftover"}, 64'(left), 64'd0);
    endtask

    logic [31:0] nom [0:7] = '{32'h0012CC, 32'h00550C, 32'h00974C, 32'h00D98C,
                               32'h011BCC, 32'h015E0C, 32'h01A04C, 32'h01E28C};

    initial begin
        int snap, found, lat2;
        logic [31:0] saved [0:ROWS-1];
        cfg_zero();
        fill_nominal();
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", outs_vec(), 64'd0);
        check("reset_address", 64'(mem_address), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        snap = c_wr;
        stray_en = 1'b1;
        repeat (3) @(negedge clk);
        stray_en = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_stray_writes", 64'(c_wr - snap), 64'd0);
        check("idle_state", 64'({busy, done}), 64'd0);

        run_case("nominal", 100, 1);
        for (int r = 0; r < ROWS; r++) check($sformatf("nominal_const[%0d]", r), 64'(acc[r]), 64'(nom[r]));

        for (int i = 0; i < 3; i++) begin
            if (i == 0) fill_nominal();
            else for (int w = 0; w <= ROWS; w++) mem[w] = {$urandom, $urandom};
            cfg_stall_addr = 4;
            cfg_stall_cycles = 3;
            for (int w = 0; w <= ROWS; w++) cfg_delay[w] = $urandom_range(1, 5);
            run_case($sformatf("stall_%0d", i), exp_latency(0), 0);
            if (i == 0)
                for (int r = 0; r < ROWS; r++) check($sformatf("stall_const[%0d]", r), 64'(acc[r]), 64'(nom[r]));
        end

        cfg_zero();
        fill_nominal();
        run_case("full_stall", exp_latency(4), 2);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int k = 0; k < 300; k++) begin
            if (mem_read && mem_address == 32'd5) begin found = 1; break; end
            @(negedge clk);
        end
        check("rst_reached_req5", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", outs_vec(), 64'd0);
        check("rst_async_address", 64'(mem_address), 64'd0);
        snap = c_wr + c_rd + c_en + c_clr;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_strobes", 64'(c_wr + c_rd + c_en + c_clr - snap), 64'd0);
        check("rst_idle", 64'({busy, done, mem_read}), 64'd0);
        run_case("after_reset", 100, 0);

        snap = c_clr;
        run_case("held_first", 100, 0);
        start = 1'b1;
        for (int r = 0; r < ROWS; r++) saved[r] = acc[r];
        @(negedge clk);
        check("held_done_pulse", 64'(done), 64'd0);
        check("held_rerun_clr", 64'(mac_clr), 64'd1);
        lat2 = -1;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin lat2 = k; break; end
        end
        start = 1'b0;
        check("held_rerun_latency", 64'(lat2), 64'd100);
        check("held_clr_total", 64'(c_clr - snap), 64'd2);
        for (int r = 0; r < ROWS; r++) check($sformatf("held_result[%0d]", r), 64'(acc[r]), 64'(saved[r]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
- Control FSM for the 8x8 matrix-vector MAC array. Fetches matrix rows A[0..ROWS-1] and vector B from an Avalon-MM-style read port, one MEM_W word per row.
- Unpacks each word byte-by-byte into the per-row A FIFOs and the shared B FIFO.
- Clears the MACs, streams the FIFOs into them for COLS cycles, and flags done.
- Sits between the memory wrapper and the FIFO/MAC datapath, one level below the board top.

Parameters:
- ROWS, 8, number of A rows, A FIFOs and MAC units
- COLS, 8, elements per row; bytes per memory word; MAC accumulate cycles
- DATA_W, 8, element width
- MEM_W, 64, memory read data width; must equal COLS*DATA_W
- ADDR_W, 32, memory address width
- BASE_ADDR, 0, word address of row 0. Row i is at BASE_ADDR+i; B is at BASE_ADDR+ROWS.
- MAC_LAT, 1, cycles after the last mac_en before MAC outputs are final

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level/pulse; sampled only in IDLE and DONE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE only
- mem_address  out  ADDR_W  word address of the current fetch
- mem_read  out  1  read request
- mem_waitrequest  in  1  slave stall; request is accepted on a cycle with mem_read=1 and mem_waitrequest=0
- mem_readdata  in  MEM_W  read data
- mem_readdatavalid  in  1  read data valid
- a_fifo_wr  out  ROWS  one-hot write enable for the A FIFOs
- b_fifo_wr  out  1  write enable for the B FIFO
- fifo_wdata  out  DATA_W  byte to write
- a_fifo_full  in  ROWS  A FIFO full flags
- b_fifo_full  in  1  B FIFO full flag
- fifo_rd  out  1  broadcast read enable to all A FIFOs and the B FIFO
- mac_clr  out  1  synchronous clear of all MAC accumulators
- mac_en  out  1  broadcast MAC accumulate enable

Behaviour:
- Reset (asynchronous, any state, including mid-fetch or mid-compute):
  - state goes to IDLE; word index, byte index and compute counter go to 0.
  - All outputs go to 0; mem_address goes to BASE_ADDR.
  - An outstanding read is abandoned; no FIFO or MAC strobe appears until the next start.
- All outputs are registered, except mem_address, which is driven from the word index.
- States and transitions:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: mac_clr=1 for exactly 1 cycle; word index=0 -> REQ.
  - REQ: mem_read=1 and mem_address=BASE_ADDR+word, both held stable while mem_waitrequest=1. On mem_waitrequest=0 -> WAIT; mem_read drops next cycle.
  - WAIT: mem_readdatavalid is honoured only in WAIT. When it is 1, capture mem_readdata into a holding register; byte index=0 -> UNPACK.
  - UNPACK: byte k is holding[DATA_W*k +: DATA_W], LSB byte first.
    - Target is A FIFO row=word when word<ROWS, else the B FIFO.
    - If the target's full flag is 1: no write; byte index holds (stall).
    - Otherwise: pulse the one-hot write enable with fifo_wdata=byte k, and advance k.
    - After byte COLS-1 is written: if word<ROWS, increment word and go to REQ; else go to COMPUTE.
  - COMPUTE: fifo_rd=1 for exactly COLS consecutive cycles. mac_en is fifo_rd delayed 1 cycle (FIFO read latency 1), so mac_en is also high for COLS cycles. Then -> DRAIN.
  - DRAIN: wait until mac_en has been low for MAC_LAT cycles -> DONE.
  - DONE: done=1; results are stable. start=1 -> CLEAR (rerun); otherwise stay.
- start is ignored while busy=1.
- Only one read is ever outstanding.
- A stray mem_readdatavalid outside WAIT is ignored.
- Latency with zero waitrequest, readdatavalid one cycle after accept and no FIFO full:
  - each word takes 10 cycles (REQ 1, WAIT 1, UNPACK 8);
  - done rises 1 + (ROWS+1)*10 + COLS + MAC_LAT = 100 clocks after the edge that samples start in IDLE.
- Address arithmetic is unsigned modulo 2^ADDR_W.

Test Plan:
- Nominal run: memory row i byte j = 0x10*i+j+1 (j=0..7), B bytes = 0x81..0x88, zero-wait memory. Required:
  - done after exactly 100 clocks;
  - MAC outputs 0x0012CC, 0x00550C, 0x00974C, 0x00D98C, 0x011BCC, 0x015E0C, 0x01A04C, 0x01E28C;
  - exactly 72 FIFO writes, 8 fifo_rd cycles, 8 mac_en cycles, 1 mac_clr pulse.
- Waitrequest stall: hold waitrequest high 3 cycles on word 4 and vary readdatavalid delay 1..5. Required:
  - mem_address and mem_read stay stable during the stall;
  - results are identical to the nominal run;
  - done is delayed by exactly the injected cycles.
- FIFO full backpressure: force a_fifo_full[2] high 4 cycles mid-UNPACK of row 2. Required:
  - no a_fifo_wr[2] during the stall;
  - byte order is preserved;
  - results are unchanged; done is 4 cycles later.
- Reset mid-operation: assert rst_n=0 during REQ of word 5, with mem_read high. Required:
  - all outputs are 0 immediately (asynchronously);
  - state is IDLE;
  - a later start completes cleanly with the nominal results.
- Start handling: start held high throughout the run. Required: no restart while busy; the rerun begins right after DONE, with mac_clr asserted again and identical results. Stray readdatavalid pulses in IDLE and UNPACK produce no writes.
